// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, op encoding,
// mstatus/mie bit positions, trap cause codes and write masks.
package csr_pkg;

   typedef enum logic [1:0] {
      CSR_NONE = 2'b00,
      CSR_RW   = 2'b01,
      CSR_RS   = 2'b10,
      CSR_RC   = 2'b11
   } csr_op_e;

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MIE      = 12'h304;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MIP      = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
   localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
   localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

   localparam int MIE_BIT  = 3;
   localparam int MPIE_BIT = 7;
   localparam int MPP_LSB  = 11;
   localparam logic [1:0] MPP_M = 2'b11;

   localparam int MTIE_BIT = 7;
   localparam int MTIP_BIT = 7;

   localparam int CAUSE_ECALL_M = 11;
   localparam int CAUSE_MTI     = 7;

   // 64-bit masters; the top truncates to XLEN.
   localparam logic [63:0] MSTATUS_RST   = 64'(MPP_M) << MPP_LSB;
   localparam logic [63:0] MSTATUS_WMASK = (64'd1 << MIE_BIT) | (64'd1 << MPIE_BIT);
   localparam logic [63:0] MIE_WMASK     = 64'd1 << MTIE_BIT;

endpackage

// File: rtl/csr_counter.sv
// Free-running XLEN-wide counter; a software write lands exactly and
// overrides the increment on the same edge.
module csr_counter #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            inc,
   input  logic            wen,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] count
);

   logic [XLEN-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (wen)
         count_d = wdata;
      else if (inc)
         count_d = count_q + XLEN'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with ecall/mret/timer-interrupt sequencing.
// Define CSR_COUNTERS_EN to implement mcycle/minstret; otherwise they read 0.
module csr_trap_unit
   import csr_pkg::*;
#(
   parameter int              XLEN        = 64,
   parameter logic [XLEN-1:0] MTVEC_RESET = '0,
   parameter int              HART_ID     = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inst_valid,
   input  logic [XLEN-1:0]   pc,
   input  logic [1:0]        csr_op,
   input  logic [11:0]       csr_addr,
   input  logic [XLEN-1:0]   csr_src,
   input  logic              ecall,
   input  logic              mret,
   input  logic              retire,
   input  logic              mtip,
   output logic [XLEN-1:0]   csr_rdata,
   output logic              illegal,
   output logic              redirect,
   output logic [XLEN-1:0]   redirect_pc,
   output logic [4*XLEN-1:0] csr_diff
);

   localparam logic [XLEN-1:0] MSTATUS_RST_X = XLEN'(MSTATUS_RST);
   localparam logic [XLEN-1:0] MSTATUS_MSK_X = XLEN'(MSTATUS_WMASK);
   localparam logic [XLEN-1:0] MIE_MSK_X     = XLEN'(MIE_WMASK);

   logic [XLEN-1:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d;
   logic [XLEN-1:0] mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;

   // Synchronous reset: present reset values on the outputs while rst_n is low.
   logic [XLEN-1:0] mstatus_v, mie_v, mtvec_v, mscratch_v, mepc_v, mcause_v;
   logic [XLEN-1:0] mcycle_v, minstret_v;

   assign mstatus_v  = rst_n ? mstatus_q  : MSTATUS_RST_X;
   assign mie_v      = rst_n ? mie_q      : '0;
   assign mtvec_v    = rst_n ? mtvec_q    : MTVEC_RESET;
   assign mscratch_v = rst_n ? mscratch_q : '0;
   assign mepc_v     = rst_n ? mepc_q     : '0;
   assign mcause_v   = rst_n ? mcause_q   : '0;

   csr_op_e         op;
   logic            hit, read_only, op_nz, write_nz, valid;
   logic            intr_take, ecall_take, mret_take, trap, csr_we;
   logic [XLEN-1:0] old_val, wval, tvec_base;

   assign op = csr_op_e'(csr_op);

   always_comb begin
      hit       = 1'b1;
      read_only = 1'b0;
      old_val   = '0;
      case (csr_addr)
         ADDR_MSTATUS:  old_val = mstatus_v;
         ADDR_MIE:      old_val = mie_v;
         ADDR_MTVEC:    old_val = mtvec_v;
         ADDR_MSCRATCH: old_val = mscratch_v;
         ADDR_MEPC:     old_val = mepc_v;
         ADDR_MCAUSE:   old_val = mcause_v;
         ADDR_MIP: begin
            old_val[MTIP_BIT] = mtip;
            read_only         = 1'b1;
         end
         ADDR_MCYCLE:   old_val = mcycle_v;
         ADDR_MINSTRET: old_val = minstret_v;
         ADDR_MHARTID: begin
            old_val   = XLEN'(HART_ID);
            read_only = 1'b1;
         end
         default:       hit = 1'b0;
      endcase
   end

   // RS/RC with a zero operand never writes, so they are legal on read-only CSRs.
   assign op_nz    = (op != CSR_NONE);
   assign write_nz = (op == CSR_RW) || (csr_src != '0);
   assign illegal  = rst_n && op_nz && (!hit || (read_only && write_nz));

   always_comb begin
      wval = csr_src;
      case (op)
         CSR_RS:  wval = old_val | csr_src;
         CSR_RC:  wval = old_val & ~csr_src;
         default: wval = csr_src;
      endcase
   end

   assign valid      = inst_valid && rst_n;
   assign intr_take  = valid && mstatus_v[MIE_BIT] && mie_v[MTIE_BIT] && mtip;
   assign ecall_take = valid && ecall && !intr_take;
   assign mret_take  = valid && mret && !intr_take && !ecall_take;
   assign trap       = intr_take || ecall_take;
   assign csr_we     = valid && op_nz && !illegal && write_nz && !trap && !mret_take;

   always_comb begin
      mstatus_d  = mstatus_q;
      mie_d      = mie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      if (csr_we) begin
         case (csr_addr)
            ADDR_MSTATUS:  mstatus_d  = (mstatus_q & ~MSTATUS_MSK_X) | (wval & MSTATUS_MSK_X);
            ADDR_MIE:      mie_d      = wval & MIE_MSK_X;
            ADDR_MTVEC:    mtvec_d    = wval;
            ADDR_MSCRATCH: mscratch_d = wval;
            ADDR_MEPC:     mepc_d     = {wval[XLEN-1:2], 2'b00};
            ADDR_MCAUSE:   mcause_d   = wval;
            default: ;
         endcase
      end
      if (trap) begin
         mepc_d              = pc;
         mcause_d            = intr_take ? {1'b1, (XLEN-1)'(CAUSE_MTI)} : XLEN'(CAUSE_ECALL_M);
         mstatus_d[MPIE_BIT] = mstatus_q[MIE_BIT];
         mstatus_d[MIE_BIT]  = 1'b0;
      end else if (mret_take) begin
         mstatus_d[MIE_BIT]  = mstatus_q[MPIE_BIT];
         mstatus_d[MPIE_BIT] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mstatus_q  <= MSTATUS_RST_X;
         mie_q      <= '0;
         mtvec_q    <= MTVEC_RESET;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
      end else begin
         mstatus_q  <= mstatus_d;
         mie_q      <= mie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
      end
   end

`ifdef CSR_COUNTERS_EN
   logic [XLEN-1:0] mcycle_cnt, minstret_cnt;

   csr_counter #(.XLEN(XLEN)) u_mcycle (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (1'b1),
      .wen   (csr_we && (csr_addr == ADDR_MCYCLE)),
      .wdata (wval),
      .count (mcycle_cnt)
   );

   csr_counter #(.XLEN(XLEN)) u_minstret (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (retire && !trap),
      .wen   (csr_we && (csr_addr == ADDR_MINSTRET)),
      .wdata (wval),
      .count (minstret_cnt)
   );

   assign mcycle_v   = rst_n ? mcycle_cnt   : '0;
   assign minstret_v = rst_n ? minstret_cnt : '0;
`else
   logic unused_retire;
   assign unused_retire = retire;
   assign mcycle_v      = '0;
   assign minstret_v    = '0;
`endif

   assign tvec_base = {mtvec_v[XLEN-1:2], 2'b00};

   // Only mode 01 vectors, and only for interrupts; modes 1x act as direct.
   always_comb begin
      redirect    = 1'b0;
      redirect_pc = mepc_v;
      if (trap) begin
         redirect    = 1'b1;
         redirect_pc = tvec_base;
         if (intr_take && (mtvec_v[1:0] == 2'b01))
            redirect_pc = tvec_base + XLEN'(CAUSE_MTI * 4);
      end else if (mret_take) begin
         redirect    = 1'b1;
         redirect_pc = mepc_v;
      end
   end

   assign csr_rdata = old_val;
   assign csr_diff  = {mtvec_v, mepc_v, mstatus_v, mcause_v};

endmodule
